// File: rtl/pmbist_pkg.sv
// Shared PMBIST definitions: address-mode encodings, direction codes and sequence span.
package pmbist_pkg;

    typedef enum logic [1:0] {
        ADMD_LIUD = 2'd0,
        ADMD_PRUD = 2'd1,
        ADMD_AC   = 2'd2,
        ADMD_GRAY = 2'd3
    } admd_t;

    localparam logic ADDR_UP   = 1'b0;
    localparam logic ADDR_DOWN = 1'b1;

    localparam int unsigned SPAN_W = 17;

    // Number of addresses in one sequence; PRUD skips the all-zero state.
    function automatic logic [SPAN_W-1:0] span(admd_t mode, int unsigned width);
        logic [SPAN_W-1:0] n;
        n = SPAN_W'(1) << width;
        if (mode == ADMD_PRUD) begin
            n = n - SPAN_W'(1);
        end
        return n;
    endfunction

endpackage

// File: rtl/pmbist_lfsr_step.sv
// Combinational one-step forward and reverse Fibonacci LFSR transition.
module pmbist_lfsr_step #(
    parameter int unsigned   W    = 8,
    parameter logic [W-1:0]  TAPS = W'(8'hB8)
) (
    input  logic [W-1:0] state_i,
    output logic [W-1:0] next_o,
    output logic [W-1:0] prev_o
);

    // Reverse step recovers the bit shifted out, relying on TAPS[W-1] being set.
    assign next_o = {state_i[W-2:0], ^(state_i & TAPS)};
    assign prev_o = {state_i[0] ^ (^(state_i[W-1:1] & TAPS[W-2:0])), state_i[W-1:1]};

endmodule

// File: rtl/pmbist_addr_gen.sv
// PMBIST address generator: linear, LFSR, complement-pair and Gray orderings, up or down.
module pmbist_addr_gen
    import pmbist_pkg::*;
#(
    parameter int unsigned            ADDR_WIDTH = 8,
    parameter logic [ADDR_WIDTH-1:0]  LFSR_TAPS  = ADDR_WIDTH'(8'hB8),
    parameter logic [ADDR_WIDTH-1:0]  LFSR_SEED  = ADDR_WIDTH'(1)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start_in,
    input  logic [1:0]             admd_in,
    input  logic                   updwn_in,
    input  logic                   hold_in,
    output logic [ADDR_WIDTH-1:0]  addr_out,
    output logic                   last_out,
    output logic                   done_out,
    output logic                   active_out
);

    localparam int unsigned W  = ADDR_WIDTH;
    localparam int unsigned NW = ADDR_WIDTH + 1;

    logic [W-1:0]  c_q, c_d;
    logic [NW-1:0] n_q, n_d;
    admd_t         mode_q, mode_d;
    logic          dir_q, dir_d;
    logic          active_q, active_d;
    logic [W-1:0]  addr_q, addr_d;
    logic          last_q, last_d;
    logic          done_q, done_d;

    logic [W-1:0]  lfsr_next, lfsr_prev;
    logic [W-1:0]  step_c;
    logic [NW-1:0] n_last;
    admd_t         admd_start;

    function automatic logic [W-1:0] start_val(admd_t m, logic dir);
        if (m == ADMD_PRUD) begin
            return LFSR_SEED;
        end
        return (dir == ADDR_DOWN) ? {W{1'b1}} : {W{1'b0}};
    endfunction

    // Counter-to-address mapping; AC pairs each value with its bitwise complement.
    function automatic logic [W-1:0] map_addr(admd_t m, logic [W-1:0] c);
        logic [W-1:0] a;
        case (m)
            ADMD_AC:   a = {c[0], c[W-1:1] ^ {(W-1){c[0]}}};
            ADMD_GRAY: a = c ^ (c >> 1);
            default:   a = c;
        endcase
        return a;
    endfunction

    pmbist_lfsr_step #(
        .W    (W),
        .TAPS (LFSR_TAPS)
    ) u_lfsr_step (
        .state_i (c_q),
        .next_o  (lfsr_next),
        .prev_o  (lfsr_prev)
    );

    assign admd_start = admd_t'(admd_in);

    always_comb begin
        step_c = c_q;
        if (mode_q == ADMD_PRUD) begin
            step_c = (dir_q == ADDR_DOWN) ? lfsr_prev : lfsr_next;
        end else begin
            step_c = (dir_q == ADDR_DOWN) ? (c_q - W'(1)) : (c_q + W'(1));
        end
        n_last = NW'(span(mode_q, W) - SPAN_W'(1));
    end

    // Next-state: start beats hold, hold beats step; idle with no start holds everything.
    always_comb begin
        c_d      = c_q;
        n_d      = n_q;
        mode_d   = mode_q;
        dir_d    = dir_q;
        active_d = active_q;
        addr_d   = addr_q;
        last_d   = last_q;
        done_d   = 1'b0;

        if (start_in) begin
            mode_d   = admd_start;
            dir_d    = updwn_in;
            n_d      = '0;
            active_d = 1'b1;
            c_d      = start_val(admd_start, updwn_in);
            addr_d   = map_addr(admd_start, c_d);
            last_d   = 1'b0;
        end else if (active_q && !hold_in) begin
            if (last_q) begin
                c_d      = start_val(mode_q, dir_q);
                n_d      = '0;
                addr_d   = map_addr(mode_q, c_d);
                last_d   = 1'b0;
                active_d = 1'b0;
                done_d   = 1'b1;
            end else begin
                c_d    = step_c;
                n_d    = n_q + NW'(1);
                addr_d = map_addr(mode_q, step_c);
                last_d = (n_d == n_last);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            c_q      <= '0;
            n_q      <= '0;
            mode_q   <= ADMD_LIUD;
            dir_q    <= ADDR_UP;
            active_q <= 1'b0;
            addr_q   <= '0;
            last_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            c_q      <= c_d;
            n_q      <= n_d;
            mode_q   <= mode_d;
            dir_q    <= dir_d;
            active_q <= active_d;
            addr_q   <= addr_d;
            last_q   <= last_d;
            done_q   <= done_d;
        end
    end

    assign addr_out   = addr_q;
    assign last_out   = last_q;
    assign done_out   = done_q;
    assign active_out = active_q;

    a_width: assert property (@(posedge clk) (ADDR_WIDTH >= 2) && (ADDR_WIDTH <= 16));
    a_taps:  assert property (@(posedge clk) LFSR_TAPS[W-1] == 1'b1);
    a_seed:  assert property (@(posedge clk) LFSR_SEED != '0);
    a_prud_nonzero: assert property (@(posedge clk) disable iff (rst)
        (active_q && (mode_q == ADMD_PRUD)) |-> (c_q != '0));

endmodule

// File: tb/tb_pmbist_addr_gen.sv
// Randomized self-checking bench for pmbist_addr_gen against an ordering-level reference model.
module tb_pmbist_addr_gen;
    import pmbist_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start_in = 1'b0;
    logic [1:0] admd_in = 2'd0;
    logic       updwn_in = 1'b0;
    logic       hold_in = 1'b0;
    logic [7:0] addr_out;
    logic       last_out;
    logic       done_out;
    logic       active_out;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] prud_tab [0:254];

    always #5 clk = ~clk;

    pmbist_addr_gen #(
        .ADDR_WIDTH (8),
        .LFSR_TAPS  (8'hB8),
        .LFSR_SEED  (8'h01)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start_in   (start_in),
        .admd_in    (admd_in),
        .updwn_in   (updwn_in),
        .hold_in    (hold_in),
        .addr_out   (addr_out),
        .last_out   (last_out),
        .done_out   (done_out),
        .active_out (active_out)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int span_of(int m);
        return (m == 1) ? 255 : 256;
    endfunction

    // k-th address of a sequence, straight from the ordering definitions.
    function automatic logic [7:0] exp_addr(int m, int dir, int k);
        int n;
        int i;
        logic [7:0] p;
        n = span_of(m);
        if (m == 1) begin
            if (dir == 0 || k == 0) return prud_tab[k];
            return prud_tab[255 - k];
        end
        i = (dir != 0) ? (n - 1 - k) : k;
        case (m)
            2: begin
                p = 8'(i >> 1);
                return i[0] ? ~p : p;
            end
            3: return 8'(i ^ (i >> 1));
            default: return 8'(i);
        endcase
    endfunction

    task automatic run_sequence(input int m, input int dir, input int hold_pct, input string name);
        int n;
        int k;
        logic adv;
        logic [7:0] prev;
        logic [10:0] got;
        logic [10:0] want;
        n = span_of(m);
        admd_in  = 2'(m);
        updwn_in = dir[0];
        hold_in  = 1'b0;
        start_in = 1'b1;
        tick();
        start_in = 1'b0;
        k = 0;
        got  = {addr_out, last_out, active_out, done_out};
        want = {exp_addr(m, dir, 0), 1'b0, 1'b1, 1'b0};
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s first: got %h want %h", name, got, want);
        end
        prev = addr_out;
        for (int it = 0; it < n * 4 + 20; it++) begin
            hold_in  = ($urandom_range(99) < hold_pct);
            admd_in  = 2'($urandom);
            updwn_in = 1'($urandom);
            adv = !hold_in;
            tick();
            if (adv) k++;
            if (k == n) break;
            got  = {addr_out, last_out, active_out, done_out};
            want = {exp_addr(m, dir, k), (k == n - 1), 1'b1, 1'b0};
            n_checks++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL %s k=%0d: got addr/last/act/done %h want %h", name, k, got, want);
            end
            if (m == 3 && adv) begin
                n_checks++;
                if ($countones(prev ^ addr_out) != 1) begin
                    n_fail++;
                    $display("FAIL %s gray_step k=%0d: got %h->%h want one bit change", name, k, prev, addr_out);
                end
            end
            prev = addr_out;
        end
        hold_in = 1'b0;
        got  = {addr_out, last_out, active_out, done_out};
        want = {exp_addr(m, dir, 0), 1'b0, 1'b0, 1'b1};
        n_checks++;
        if (k != n || got !== want) begin
            n_fail++;
            $display("FAIL %s done: got %h (k=%0d) want %h (k=%0d)", name, got, k, want, n);
        end
        if (m == 3) begin
            n_checks++;
            if ($countones(prev ^ addr_out) != 1) begin
                n_fail++;
                $display("FAIL %s gray_wrap: got %h->%h want one bit change", name, prev, addr_out);
            end
        end
        tick();
        got  = {addr_out, last_out, active_out, done_out};
        want = {exp_addr(m, dir, 0), 1'b0, 1'b0, 1'b0};
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s after_done: got %h want %h", name, got, want);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        n_checks++;
        if ({addr_out, last_out, active_out, done_out} !== 11'h0) begin
            n_fail++;
            $display("FAIL reset: got %h want 000", {addr_out, last_out, active_out, done_out});
        end
        rst = 1'b0;
        hold_in = 1'b1;
        tick();
        hold_in = 1'b0;
        tick();
        n_checks++;
        if ({addr_out, last_out, active_out, done_out} !== 11'h0) begin
            n_fail++;
            $display("FAIL idle_after_reset: got %h want 000", {addr_out, last_out, active_out, done_out});
        end
    endtask

    task automatic test_liud();
        run_sequence(0, 0, 0, "liud_up");
        run_sequence(0, 1, 30, "liud_down");
    endtask

    task automatic test_prud();
        logic [7:0] first [0:4];
        first[0] = 8'h01; first[1] = 8'h02; first[2] = 8'h04; first[3] = 8'h08; first[4] = 8'h11;
        admd_in  = 2'd1;
        updwn_in = 1'b0;
        start_in = 1'b1;
        tick();
        start_in = 1'b0;
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if (addr_out !== first[i]) begin
                n_fail++;
                $display("FAIL prud_first step=%0d: got %h want %h", i, addr_out, first[i]);
            end
            tick();
        end
        run_sequence(1, 0, 20, "prud_up");
        run_sequence(1, 1, 20, "prud_down");
    endtask

    task automatic test_ac();
        run_sequence(2, 0, 25, "ac_up");
        run_sequence(2, 1, 25, "ac_down");
    endtask

    task automatic test_gray();
        run_sequence(3, 0, 25, "gray_up");
        run_sequence(3, 1, 25, "gray_down");
    endtask

    task automatic test_hold();
        logic [10:0] got;
        admd_in  = 2'd0;
        updwn_in = 1'b0;
        start_in = 1'b1;
        tick();
        start_in = 1'b0;
        for (int i = 0; i < 16; i++) tick();
        hold_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            admd_in  = 2'($urandom);
            updwn_in = 1'($urandom);
            tick();
            got = {addr_out, last_out, active_out, done_out};
            n_checks++;
            if (got !== {8'h10, 1'b0, 1'b1, 1'b0}) begin
                n_fail++;
                $display("FAIL hold_mid cyc=%0d: got %h want 082", i, got);
            end
        end
        hold_in = 1'b0;
        for (int k = 17; k < 256; k++) begin
            tick();
            got = {addr_out, last_out, active_out, done_out};
            n_checks++;
            if (got !== {8'(k), (k == 255), 1'b1, 1'b0}) begin
                n_fail++;
                $display("FAIL hold_resume k=%0d: got %h want %h", k, got, {8'(k), (k == 255), 1'b1, 1'b0});
            end
        end
        hold_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            got = {addr_out, last_out, active_out, done_out};
            n_checks++;
            if (got !== {8'hFF, 1'b1, 1'b1, 1'b0}) begin
                n_fail++;
                $display("FAIL hold_last cyc=%0d: got %h want 7fe", i, got);
            end
        end
        hold_in = 1'b0;
        tick();
        got = {addr_out, last_out, active_out, done_out};
        n_checks++;
        if (got !== {8'h00, 1'b0, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL hold_release_done: got %h want 001", got);
        end
        hold_in = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            got = {addr_out, last_out, active_out, done_out};
            n_checks++;
            if (got !== 11'h0) begin
                n_fail++;
                $display("FAIL hold_idle cyc=%0d: got %h want 000", i, got);
            end
        end
        hold_in = 1'b0;
    endtask

    task automatic test_restart();
        logic [10:0] got;
        admd_in  = 2'd0;
        updwn_in = 1'b0;
        start_in = 1'b1;
        tick();
        start_in = 1'b0;
        for (int i = 0; i < 64; i++) tick();
        n_checks++;
        if (addr_out !== 8'h40) begin
            n_fail++;
            $display("FAIL restart_pre: got %h want 40", addr_out);
        end
        start_in = 1'b1;
        tick();
        start_in = 1'b0;
        got = {addr_out, last_out, active_out, done_out};
        n_checks++;
        if (got !== {8'h00, 1'b0, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL restart_liud: got %h want 002", got);
        end
        tick();
        tick();
        admd_in  = 2'd1;
        start_in = 1'b1;
        tick();
        start_in = 1'b0;
        got = {addr_out, last_out, active_out, done_out};
        n_checks++;
        if (got !== {8'h01, 1'b0, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL restart_prud: got %h want 00a", got);
        end
        tick();
        got = {addr_out, last_out, active_out, done_out};
        n_checks++;
        if (got !== {8'h02, 1'b0, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL restart_prud_step: got %h want 012", got);
        end
    endtask

    task automatic test_reset_mid();
        logic [10:0] got;
        for (int i = 0; i < 5; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        got = {addr_out, last_out, active_out, done_out};
        n_checks++;
        if (got !== 11'h0) begin
            n_fail++;
            $display("FAIL reset_mid: got %h want 000", got);
        end
        tick();
        got = {addr_out, last_out, active_out, done_out};
        n_checks++;
        if (got !== 11'h0) begin
            n_fail++;
            $display("FAIL reset_mid_after: got %h want 000", got);
        end
        run_sequence(0, 0, 10, "post_reset_liud");
    endtask

    initial begin
        logic [7:0] s;
        s = 8'h01;
        for (int i = 0; i < 255; i++) begin
            prud_tab[i] = s;
            s = {s[6:0], ^(s & 8'hB8)};
        end
        test_reset();
        test_liud();
        test_prud();
        test_ac();
        test_gray();
        test_hold();
        test_restart();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pmbist_addr_gen.md
# pmbist_addr_gen

Parametrised PMBIST address generator, the successor to the fixed 8-bit address counter. It produces one memory address per step in one of four orderings: linear, pseudo-random LFSR, address-complement pairs and Gray code. It runs in either direction and explicitly flags the last address and sequence completion. It sits between the PMBIST march controller and the memory-under-test address port.

## Interface
- `ADDR_WIDTH`, 8: address width W, legal range 2..16.
- `LFSR_TAPS`, 8'hB8: Fibonacci tap mask, bit i set means state bit i is in the feedback. Bit W-1 must be set and the polynomial must be maximal-length. The default is x^8+x^6+x^5+x^4+1.
- `LFSR_SEED`, 1: PRUD start state, must be nonzero.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset, synchronous, active-high.
- `start_in`  in  1  load the first address of a new sequence.
- `admd_in`  in  2  address mode: 0 LIUD, 1 PRUD, 2 AC, 3 GRAY. Sampled only with `start_in`.
- `updwn_in`  in  1  direction: 0 up, 1 down. Sampled only with `start_in`.
- `hold_in`  in  1  freeze the address (march element ops in progress).
- `addr_out`  out  W  current address, registered.
- `last_out`  out  1  `addr_out` is the final address of the sequence.
- `done_out`  out  1  one-cycle pulse, sequence complete.
- `active_out`  out  1  sequence in progress.

## Operation
- Internal state: counter `c` (W bits), step counter `n` (W+1 bits), latched mode, latched direction, active flag.
- Sequence span N is 2^W for LIUD, AC and GRAY, and 2^W-1 for PRUD (zero is excluded).
- Priority: `rst` > `start_in` > `hold_in` > step. A step occurs every cycle when active and not held.
- Start behaviour:
  - Latch the mode and direction, set `n`=0, set active.
  - Load `c`: LIUD/AC/GRAY load 0 for up and 2^W-1 for down. PRUD loads `LFSR_SEED` in both directions.
  - `start_in` while active restarts the sequence immediately. It does not generate `done_out`.
- Step behaviour:
  - `c` advances and `n` is incremented.
  - LIUD/AC/GRAY: `c` is incremented (up) or decremented (down), modulo 2^W.
  - PRUD up: `c` ← {c[W-2:0], ^(c & TAPS)}.
  - PRUD down (exact inverse of up): `c` ← {c[0] ^ ^(c[W-1:1] & TAPS[W-2:0]), c[W-1:1]}.
- Address mapping, applied to the new `c` and registered in the same edge as `c`:
  - LIUD and PRUD: `addr_out` = c.
  - AC: `addr_out` = {c[0], c[W-1:1] ^ {W-1{c[0]}}}. Each even/odd pair is a pair of bitwise complements. Down visits the exact reverse of the up order.
  - GRAY: `addr_out` = c ^ (c >> 1).
- `last_out` = active and `n` == N-1. It is registered and coincident with `addr_out`.
- Step taken while `last_out`=1:
  - `c` wraps to the start value and `addr_out` shows the start address.
  - `done_out` pulses for one cycle and active clears.
  - With active clear, `addr_out` stays constant until the next `start_in`.
- Changes on `admd_in`/`updwn_in` mid-sequence have no effect.
- `hold_in` while inactive has no effect.

## Timing
- Reset values: `addr_out`=0, `last_out`=0, `done_out`=0, `active_out`=0, `c`=0, `n`=0. Reset mid-sequence aborts without a `done_out` pulse.
- `start_in` at edge t: the first address, `active_out`=1 and `last_out`=0 are visible after edge t. Exception: `last_out` is visible immediately when N=1, which cannot occur because W≥2.
- Each unheld active cycle advances exactly one address. The latency from step to `addr_out` is one cycle.
- `done_out` is asserted in the cycle after the edge that consumed the last address. `active_out` falls in that same cycle.
- `hold_in` asserted in the last-address cycle: `last_out` and `addr_out` stay unchanged, with no `done_out`, until the hold is released.

## Structure
- Shared package `pmbist_pkg`:
  - `admd_t` encodings (LIUD, PRUD, AC, GRAY).
  - `ADDR_UP`=0 and `ADDR_DOWN`=1.
  - A span function, N as a function of mode and width.
- Sub-module `pmbist_lfsr_step`: combinational next/previous LFSR state, parametrised by W and TAPS. It is reusable by the data-background generator.
- Simulation assertions:
  - `LFSR_TAPS`[W-1] is set.
  - `LFSR_SEED` is nonzero.
  - In PRUD, `c` never becomes 0.

## Test plan
All scenarios use W=8 and the default parameters.
- LIUD up: `start_in`, mode 0, up → addresses 0x00, 0x01, … 0xFF. `last_out` is high only with 0xFF. Next cycle: `done_out`=1, `addr_out`=0x00, `active_out`=0.
- PRUD: start up → 0x01, 0x02, 0x04, 0x08, 0x11. `last_out` at step 254 and `done_out` after 255 steps. Start down from 0x11-equivalent state → previous state is 0x08.
- AC: up → 0x00, 0xFF, 0x01, 0xFE, …, 0x80 last. Down → 0x80, 0x7F, …, 0xFF, 0x00 last.
- GRAY: up → 0x00, 0x01, 0x03, 0x02, 0x06. Exactly one bit toggles per step across all 256 addresses, including the wrap.
- Hold and mode change: `hold_in` for 3 cycles at 0x10 → 0x10 is held and `n` does not move. Toggling `admd_in`/`updwn_in` mid-sequence changes nothing. Holding in the last cycle delays `done_out`.
- Restart and reset: `start_in` at address 0x40 reloads 0x00 with no `done_out`. `rst` mid-sequence → all outputs 0 the next cycle.
